// File: rtl/beta_engine_if.sv
// Branch-metric input and beta output bundle of the beta engine.
// The master side is the upstream/downstream pair; the slave side is the engine.
interface beta_engine_if #(
  parameter int W = 16
) ();
  logic [15:0]         blklen;
  logic                out_tail;
  logic                valid_branch;
  logic signed [W-1:0] init_branch1;
  logic signed [W-1:0] init_branch2;
  logic                in_ready;
  logic signed [W-1:0] beta_0;
  logic signed [W-1:0] beta_1;
  logic signed [W-1:0] beta_2;
  logic signed [W-1:0] beta_3;
  logic signed [W-1:0] beta_4;
  logic signed [W-1:0] beta_5;
  logic signed [W-1:0] beta_6;
  logic signed [W-1:0] beta_7;
  logic                valid_beta;
  logic                last_beta;
  logic                busy;
  logic                err_len;

  modport master (
    output blklen, out_tail, valid_branch, init_branch1, init_branch2,
    input  in_ready, beta_0, beta_1, beta_2, beta_3, beta_4, beta_5, beta_6, beta_7,
    input  valid_beta, last_beta, busy, err_len
  );

  modport slave (
    input  blklen, out_tail, valid_branch, init_branch1, init_branch2,
    output in_ready, beta_0, beta_1, beta_2, beta_3, beta_4, beta_5, beta_6, beta_7,
    output valid_beta, last_beta, busy, err_len
  );
endinterface

// File: rtl/beta_engine.sv
// Backward (beta) state-metric engine for an 8-state max-log-MAP SISO decoder.
// Buffers one block of branch metrics in a LIFO, then runs the recursion one step per cycle.
module beta_engine #(
  parameter int W          = 16,
  parameter int MAX_BLKLEN = 6144,
  parameter int NEG_INIT   = -128
) (
  input logic          clk,
  input logic          rst,
  beta_engine_if.slave bus
);

  localparam int          DEPTH = MAX_BLKLEN + 4;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] MAX_N = 32'(MAX_BLKLEN);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
  typedef logic signed [W-1:0] metric_t;
  typedef logic signed [W:0]   wide_t;
  typedef logic signed [W+1:0] diff_t;

  localparam metric_t NEG_M  = metric_t'(NEG_INIT);
  localparam diff_t   SAT_HI = {3'b000, {(W-1){1'b1}}};
  localparam diff_t   SAT_LO = {3'b111, {(W-1){1'b0}}};

  // One add-compare-select: max(p + g, q - g) at W+1 bits, so it never wraps.
  function automatic wide_t bfly(input metric_t p, input metric_t q, input metric_t g);
    wide_t s;
    wide_t d;
    s = {p[W-1], p} + {g[W-1], g};
    d = {q[W-1], q} - {g[W-1], g};
    return (s > d) ? s : d;
  endfunction

  function automatic metric_t norm(input wide_t x, input wide_t r0);
    diff_t d;
    d = {x[W], x} - {r0[W], r0};
    if (d > SAT_HI) return SAT_HI[W-1:0];
    if (d < SAT_LO) return SAT_LO[W-1:0];
    return d[W-1:0];
  endfunction

  state_t          state, state_nx;
  logic            drop;
  logic            tail_reg;
  logic [AW-1:0]   n_reg, last_addr, wr_addr, rd_addr, waddr;
  logic            issue_done;
  logic            in_ready, beat, len_bad;
  logic            wr_en, start, bad_len, go_run, issue;

  logic [2*W-1:0]  mem [DEPTH];
  logic [2*W-1:0]  rd_data;
  logic            rd_vld, rd_emit, rd_last;

  metric_t         g1, g2;
  wide_t           raw  [8];
  metric_t         b    [8];
  metric_t         b_nx [8];
  metric_t         beta_q [8];
  logic            valid_q, last_q, err_q;

  assign in_ready = (state == S_IDLE) || (state == S_LOAD);
  assign beat     = bus.valid_branch & in_ready;
  assign len_bad  = (bus.blklen == 16'd0) || (32'(bus.blklen) > MAX_N);
  assign waddr    = (state == S_IDLE) ? '0 : wr_addr;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    start    = 1'b0;
    bad_len  = 1'b0;
    go_run   = 1'b0;
    issue    = 1'b0;
    case (state)
      S_IDLE: begin
        if (beat && !drop) begin
          if (len_bad) begin
            bad_len = 1'b1;
          end else begin
            start    = 1'b1;
            wr_en    = 1'b1;
            state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (beat) begin
          wr_en = 1'b1;
          if (wr_addr == last_addr) begin
            go_run   = 1'b1;
            state_nx = S_RUN;
          end
        end
      end
      S_RUN: begin
        issue = !issue_done;
        if (valid_q && last_q) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      drop       <= 1'b0;
      tail_reg   <= 1'b0;
      n_reg      <= '0;
      last_addr  <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      issue_done <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= bad_len;
      // A rejected block is skipped until the upstream drops valid for a cycle.
      drop  <= bad_len | (drop & bus.valid_branch);
      if (start) begin
        n_reg     <= AW'(bus.blklen);
        last_addr <= AW'(32'(bus.blklen) + 32'd3);
        tail_reg  <= bus.out_tail;
      end
      if (start) wr_addr <= AW'(1);
      else if (wr_en) wr_addr <= wr_addr + 1'b1;
      if (go_run) begin
        rd_addr    <= last_addr;
        issue_done <= 1'b0;
      end else if (issue) begin
        if (rd_addr == '0) issue_done <= 1'b1;
        else rd_addr <= rd_addr - 1'b1;
      end
    end
  end

  // NOTE: the LIFO array and its read register have no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= {bus.init_branch1, bus.init_branch2};
    if (issue) rd_data <= mem[rd_addr];
  end

  always_comb begin
    g1     = rd_data[2*W-1:W];
    g2     = rd_data[W-1:0];
    raw[0] = bfly(b[0], b[4], g1);
    raw[1] = bfly(b[4], b[0], g1);
    raw[2] = bfly(b[5], b[1], g2);
    raw[3] = bfly(b[1], b[5], g2);
    raw[4] = bfly(b[2], b[6], g2);
    raw[5] = bfly(b[6], b[2], g2);
    raw[6] = bfly(b[7], b[3], g1);
    raw[7] = bfly(b[3], b[7], g1);
    for (int i = 0; i < 8; i++) b_nx[i] = norm(raw[i], raw[0]);
  end

  // Tail steps with out_tail=0 still advance the metrics but never reach the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld  <= 1'b0;
      rd_emit <= 1'b0;
      rd_last <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        b[i]      <= '0;
        beta_q[i] <= '0;
      end
    end else begin
      rd_vld  <= issue;
      rd_emit <= tail_reg | (rd_addr < n_reg);
      rd_last <= (rd_addr == '0);
      valid_q <= rd_vld & rd_emit;
      last_q  <= rd_vld & rd_emit & rd_last;
      if (go_run) begin
        b[0] <= '0;
        for (int i = 1; i < 8; i++) b[i] <= NEG_M;
      end else if (rd_vld) begin
        b <= b_nx;
      end
      if (rd_vld && rd_emit) beta_q <= b_nx;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.busy       = (state != S_IDLE);
  assign bus.err_len    = err_q;
  assign bus.valid_beta = valid_q;
  assign bus.last_beta  = last_q;
  assign bus.beta_0     = beta_q[0];
  assign bus.beta_1     = beta_q[1];
  assign bus.beta_2     = beta_q[2];
  assign bus.beta_3     = beta_q[3];
  assign bus.beta_4     = beta_q[4];
  assign bus.beta_5     = beta_q[5];
  assign bus.beta_6     = beta_q[6];
  assign bus.beta_7     = beta_q[7];

endmodule

// File: tb/tb_beta_engine.sv
// Scoreboard bench for beta_engine: stimulus pushes expected betas, a negedge monitor pops and compares.
module tb_beta_engine;

  localparam int W        = 16;
  localparam int MAXB     = 6144;
  localparam int NEG_INIT = -128;
  localparam int CW       = 136;

  typedef struct packed {
    logic             last;
    logic [7:0][15:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  beta_engine_if #(.W(W)) bus ();

  beta_engine #(.W(W), .MAX_BLKLEN(MAXB), .NEG_INIT(NEG_INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t             exp_q[$];
  int               n_pass  = 0;
  int               n_total = 0;
  int               err_cnt = 0;
  bit               sat_phase = 1'b0;
  bit               sat_seen  = 1'b0;
  int               g1v [MAXB+4];
  int               g2v [MAXB+4];
  logic [7:0][15:0] mon_act;
  exp_t             mon_e;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Golden max-log recursion in plain integers, with saturation to W bits.
  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic push_model(input int n, input bit tail);
    int   b [8];
    int   r [8];
    int   g1, g2;
    exp_t e;
    b[0] = 0;
    for (int i = 1; i < 8; i++) b[i] = NEG_INIT;
    for (int a = n + 3; a >= 0; a--) begin
      g1 = g1v[a];
      g2 = g2v[a];
      r[0] = mx(b[0] + g1, b[4] - g1);
      r[1] = mx(b[4] + g1, b[0] - g1);
      r[2] = mx(b[5] + g2, b[1] - g2);
      r[3] = mx(b[1] + g2, b[5] - g2);
      r[4] = mx(b[2] + g2, b[6] - g2);
      r[5] = mx(b[6] + g2, b[2] - g2);
      r[6] = mx(b[7] + g1, b[3] - g1);
      r[7] = mx(b[3] + g1, b[7] - g1);
      for (int i = 0; i < 8; i++) b[i] = clamp(r[i] - r[0]);
      if (tail || a < n) begin
        e.last = (a == 0);
        for (int i = 0; i < 8; i++) e.b[i] = 16'(b[i]);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_vec(input logic [127:0] v, input bit last);
    exp_t e;
    e.last = last;
    e.b    = v;
    exp_q.push_back(e);
  endtask

  task automatic fill_g(input int v1, input int v2);
    for (int i = 0; i < MAXB + 4; i++) begin
      g1v[i] = v1;
      g2v[i] = v2;
    end
  endtask

  // Beats go out at posedge+1; blklen/out_tail are scrambled after the first beat.
  task automatic send_block(input int n, input bit tail, input bit gap, input bit chk_ready);
    for (int k = 0; k < n + 4; k++) begin
      if (k == 0) begin
        bus.blklen   = 16'(n);
        bus.out_tail = tail;
      end
      bus.valid_branch = 1'b1;
      bus.init_branch1 = 16'(g1v[k]);
      bus.init_branch2 = 16'(g2v[k]);
      if (chk_ready) check("in_ready_load", CW'(bus.in_ready), CW'(1'b1));
      @(posedge clk); #1;
      bus.valid_branch = 1'b0;
      bus.blklen       = 16'd2;
      bus.out_tail     = ~tail;
      if (gap && (k % 2 == 0)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_last(input int budget);
    int cyc = 0;
    bit found = 1'b0;
    bit ready_hi = 1'b0;
    while (!found && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.in_ready) ready_hi = 1'b1;
      if (bus.valid_beta && bus.last_beta) found = 1'b1;
    end
    check("last_beta_seen", CW'(found), CW'(1'b1));
    check("in_ready_low_run", CW'(ready_hi), CW'(1'b0));
    @(negedge clk);
    check("done_state", CW'({bus.busy, bus.in_ready, bus.valid_beta}), CW'(3'b100));
    @(negedge clk);
    check("idle_state", CW'({bus.busy, bus.in_ready}), CW'(2'b01));
    check("sb_drained", CW'(exp_q.size()), CW'(0));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.err_len) err_cnt++;
      if (bus.valid_beta) begin
        mon_act = {bus.beta_7, bus.beta_6, bus.beta_5, bus.beta_4,
                   bus.beta_3, bus.beta_2, bus.beta_1, bus.beta_0};
        if (sat_phase)
          for (int i = 0; i < 8; i++) if (mon_act[i] == 16'h8000) sat_seen = 1'b1;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beta: got %0h with no expected entry", mon_act);
        end else begin
          mon_e = exp_q.pop_front();
          check("beta_vec", CW'({bus.last_beta, mon_act}), CW'({mon_e.last, mon_e.b}));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] lat;
    bit         seen;
    bus.blklen       = 16'd0;
    bus.out_tail     = 1'b0;
    bus.valid_branch = 1'b0;
    bus.init_branch1 = '0;
    bus.init_branch2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", CW'(bus.in_ready), CW'(1'b1));
    check("rst_busy", CW'(bus.busy), CW'(1'b0));
    check("rst_flags", CW'({bus.valid_beta, bus.last_beta, bus.err_len}), CW'(3'b000));
    check("rst_betas", CW'({bus.beta_7, bus.beta_6, bus.beta_5, bus.beta_4,
                            bus.beta_3, bus.beta_2, bus.beta_1, bus.beta_0}), CW'(0));
    @(posedge clk); #1 rst = 1'b1;

    // N=4, out_tail=1, all-zero branches: 8 outputs, hand-computed
    fill_g(0, 0);
    push_vec({{6{16'hff80}}, 32'h0}, 1'b0);
    push_vec({{4{16'hff80}}, 64'h0}, 1'b0);
    for (int i = 0; i < 5; i++) push_vec(128'h0, 1'b0);
    push_vec(128'h0, 1'b1);
    send_block(4, 1'b1, 1'b0, 1'b0);
    @(negedge clk); lat[0] = bus.valid_beta;
    @(negedge clk); lat[1] = bus.valid_beta;
    @(negedge clk); lat[2] = bus.valid_beta;
    check("first_out_latency", CW'(lat), CW'(3'b100));
    wait_last(40);

    // Same stimulus, out_tail=0: only outputs 5..8 of the previous block
    for (int i = 0; i < 3; i++) push_vec(128'h0, 1'b0);
    push_vec(128'h0, 1'b1);
    send_block(4, 1'b0, 1'b0, 1'b0);
    wait_last(40);

    // Reset while betas are streaming
    push_vec({{6{16'hff80}}, 32'h0}, 1'b0);
    push_vec({{4{16'hff80}}, 64'h0}, 1'b0);
    send_block(4, 1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.valid_beta) seen = 1'b1;
    end
    check("mid_run_valid_seen", CW'(seen), CW'(1'b1));
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ctrl", CW'({bus.valid_beta, bus.last_beta, bus.busy, bus.in_ready}), CW'(4'b0001));
    check("mid_rst_betas", CW'({bus.beta_7, bus.beta_6, bus.beta_5, bus.beta_4,
                                bus.beta_3, bus.beta_2, bus.beta_1, bus.beta_0}), CW'(0));
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;

    // N=6, directed small branches, gapped valid; blklen/out_tail scrambled after latch
    fill_g(0, 0);
    g1v[0:9] = '{12, -37, 63, -64, 5, -20, 44, -8, 27, -51};
    g2v[0:9] = '{-9, 58, -33, 17, -64, 40, -2, 61, -45, 3};
    push_model(6, 1'b1);
    send_block(6, 1'b1, 1'b1, 1'b1);
    check("in_ready_after_beat10", CW'(bus.in_ready), CW'(1'b0));
    wait_last(60);

    // Saturation: g1=+30000 every step
    fill_g(30000, 0);
    push_model(4, 1'b1);
    sat_phase = 1'b1;
    send_block(4, 1'b1, 1'b0, 1'b0);
    wait_last(40);
    sat_phase = 1'b0;
    check("saturation_hit", CW'(sat_seen), CW'(1'b1));

    // Illegal lengths: err_len once each, held valid is ignored
    bus.blklen = 16'd0;
    bus.valid_branch = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("err_len_zero", CW'(bus.err_len), CW'(1'b1));
    @(posedge clk); #1 bus.valid_branch = 1'b0;
    @(posedge clk); #1;
    bus.blklen = 16'(MAXB + 1);
    bus.valid_branch = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("err_len_big", CW'(bus.err_len), CW'(1'b1));
    @(posedge clk); #1 bus.valid_branch = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("err_len_count", CW'(err_cnt), CW'(2));
    check("err_busy", CW'({bus.busy, bus.in_ready}), CW'(2'b01));

    // Largest legal block
    fill_g(0, 0);
    push_model(MAXB, 1'b0);
    send_block(MAXB, 1'b0, 1'b0, 1'b0);
    wait_last(MAXB + 40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
